// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared phase encoding and one-hot phase enables for the y86_seq core
package y86_pkg;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_FETCH,
      PH_DECODE,
      PH_EXEC,
      PH_MEM,
      PH_WB,
      PH_HALTED,
      PH_FAULT
   } phase_e;

   localparam logic [4:0] UE_NONE   = 5'b00000;
   localparam logic [4:0] UE_FETCH  = 5'b00001;
   localparam logic [4:0] UE_DECODE = 5'b00010;
   localparam logic [4:0] UE_EXEC   = 5'b00100;
   localparam logic [4:0] UE_MEM    = 5'b01000;
   localparam logic [4:0] UE_WB     = 5'b10000;

   function automatic logic phase_active(input phase_e p);
      return (p == PH_FETCH) || (p == PH_DECODE) || (p == PH_EXEC) ||
             (p == PH_MEM)   || (p == PH_WB);
   endfunction

endpackage

// File: rtl/y86_wait_timer.sv
// rtl/y86_wait_timer.sv - bus wait-state counter, saturating at WAIT_MAX with an expiry flag
module y86_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int            CW   = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] MAXV = CW'(WAIT_MAX);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAXV)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_expired = (r_cnt == MAXV);

endmodule

// File: rtl/y86_phase_ctrl.sv
// rtl/y86_phase_ctrl.sv - y86_seq phase sequencer with bus wait states, debug run/step/halt and counters
module y86_phase_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int WAIT_MAX  = 15,
   parameter bit START_RUN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_mem_ready,
   input  logic             i_is_mem,
   input  logic             i_is_halt,
   input  logic             i_dbg_run,
   input  logic             i_dbg_step,
   input  logic             i_dbg_halt_req,
   output logic [4:0]       o_ue,
   output logic             o_halted,
   output logic             o_idle,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_instr_count,
   output logic [CNT_W-1:0] o_cyc_count
);

   localparam phase_e RST_PH = START_RUN ? PH_FETCH : PH_IDLE;

   phase_e           r_state;
   phase_e           w_next;
   logic             r_step_mode;
   logic             w_step_next;
   logic             r_halt_pend;
   logic             w_pend_next;
   logic [CNT_W-1:0] r_instr;
   logic [CNT_W-1:0] r_cyc;
   logic             w_active;
   logic             w_waiting;
   logic             w_expired;

   assign w_active  = phase_active(r_state);
   assign w_waiting = ((r_state == PH_FETCH) || (r_state == PH_MEM)) && !i_mem_ready;

   y86_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (!w_waiting),
      .i_inc     (w_waiting),
      .o_expired (w_expired)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= RST_PH;
         r_step_mode <= 1'b0;
         r_halt_pend <= 1'b0;
         r_instr     <= '0;
         r_cyc       <= '0;
      end else begin
         r_state     <= w_next;
         r_step_mode <= w_step_next;
         r_halt_pend <= w_pend_next;
         if (w_active)          r_cyc   <= r_cyc + CNT_W'(1);
         if (r_state == PH_WB)  r_instr <= r_instr + CNT_W'(1);
      end
   end

   // A halt request arriving during WB still stops at this boundary.
   always_comb begin
      w_next      = r_state;
      w_step_next = r_step_mode;
      w_pend_next = r_halt_pend | (w_active & i_dbg_halt_req);
      case (r_state)
         PH_IDLE: begin
            if (!i_dbg_halt_req) begin
               if (i_dbg_run) begin
                  w_next      = PH_FETCH;
                  w_step_next = 1'b0;
               end else if (i_dbg_step) begin
                  w_next      = PH_FETCH;
                  w_step_next = 1'b1;
               end
            end
         end
         PH_FETCH: begin
            if (i_mem_ready)    w_next = PH_DECODE;
            else if (w_expired) w_next = PH_FAULT;
         end
         PH_DECODE: w_next = i_is_halt ? PH_HALTED : PH_EXEC;
         PH_EXEC:   w_next = i_is_mem ? PH_MEM : PH_WB;
         PH_MEM: begin
            if (i_mem_ready)    w_next = PH_WB;
            else if (w_expired) w_next = PH_FAULT;
         end
         PH_WB: begin
            w_next      = (r_step_mode || w_pend_next) ? PH_IDLE : PH_FETCH;
            w_step_next = 1'b0;
            w_pend_next = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_ue = UE_NONE;
      case (r_state)
         PH_FETCH:  o_ue = UE_FETCH;
         PH_DECODE: o_ue = UE_DECODE;
         PH_EXEC:   o_ue = UE_EXEC;
         PH_MEM:    o_ue = UE_MEM;
         PH_WB:     o_ue = UE_WB;
         default:   o_ue = UE_NONE;
      endcase
   end

   assign o_halted      = (r_state == PH_HALTED);
   assign o_idle        = (r_state == PH_IDLE);
   assign o_fault       = (r_state == PH_FAULT);
   assign o_instr_count = r_instr;
   assign o_cyc_count   = r_cyc;

endmodule
